// File: rtl/multiram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM bank between
// three read and three write requesters, with a 2-cycle tagged read return.
module multiram_bank_arbiter #(
  parameter int unsigned na = 16,
  parameter int unsigned nd = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3*na-1:0]   r_addr,
  input  logic [2:0]        r_avalid,
  output logic [2:0]        r_aready,
  output logic [3*nd-1:0]   r_data,
  output logic [2:0]        r_dvalid,
  input  logic [3*na-1:0]   w_addr,
  input  logic [3*nd-1:0]   w_data,
  input  logic [2:0]        w_valid,
  output logic [2:0]        w_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [na-1:0]     ram_addr,
  output logic [nd-1:0]     ram_wdata,
  input  logic [nd-1:0]     ram_rdata
);

  localparam int unsigned NREQ = 6;
  localparam int unsigned PW   = 3;
  localparam int unsigned TW   = 2;

  logic [NREQ-1:0] w_req;
  logic            w_gnt_vld;
  logic [PW-1:0]   w_gnt_idx;
  logic [PW-1:0]   w_cand;
  logic [TW-1:0]   w_port;
  logic            w_is_wr;

  logic [PW-1:0]   r_ptr;
  logic            r_p1_valid;
  logic [TW-1:0]   r_p1_tag;

  // Interleave requests into arbitration order r0, w0, r1, w1, r2, w2
  always_comb begin
    w_req = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_req[2*k]   = r_avalid[k];
      w_req[2*k+1] = w_valid[k];
    end
  end

  // First active request at or after the pointer wins; nothing wins in reset
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand = PW'((32'(r_ptr) + i) % NREQ);
      if (!w_gnt_vld && w_req[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (reset) begin
      w_gnt_vld = 1'b0;
    end
  end

  assign w_port  = w_gnt_idx[2:1];
  assign w_is_wr = w_gnt_idx[0];

  // Decode the grant into ready strobes and the RAM command
  always_comb begin
    r_aready  = '0;
    w_ready   = '0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_gnt_vld) begin
      ram_en = 1'b1;
      if (w_is_wr) begin
        w_ready[w_port] = 1'b1;
        ram_we          = 1'b1;
        ram_addr        = w_addr[w_port*na +: na];
        ram_wdata       = w_data[w_port*nd +: nd];
      end else begin
        r_aready[w_port] = 1'b1;
        ram_addr         = r_addr[w_port*na +: na];
      end
    end
  end

  // Pointer advance and read return pipeline (tag -> data capture -> dvalid)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_p1_valid <= 1'b0;
      r_p1_tag   <= '0;
      r_dvalid   <= '0;
      r_data     <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
      end
      r_p1_valid <= w_gnt_vld && !w_is_wr;
      r_p1_tag   <= w_port;
      r_dvalid   <= '0;
      if (r_p1_valid) begin
        r_dvalid[r_p1_tag]          <= 1'b1;
        r_data[r_p1_tag*nd +: nd]   <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_multiram_bank_arbiter.sv
// Bench for multiram_bank_arbiter: RAM model plus a round-robin/shadow-memory
// reference model; directed scenarios followed by randomized traffic.
module tb_multiram_bank_arbiter;

  localparam int unsigned NA = 16;
  localparam int unsigned ND = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [3*NA-1:0] r_addr;
  logic [2:0]      r_avalid;
  logic [2:0]      r_aready;
  logic [3*ND-1:0] r_data;
  logic [2:0]      r_dvalid;
  logic [3*NA-1:0] w_addr;
  logic [3*ND-1:0] w_data;
  logic [2:0]      w_valid;
  logic [2:0]      w_ready;
  logic            ram_en;
  logic            ram_we;
  logic [NA-1:0]   ram_addr;
  logic [ND-1:0]   ram_wdata;
  logic [ND-1:0]   ram_rdata;

  always #5 clk = ~clk;

  multiram_bank_arbiter #(.na(NA), .nd(ND)) dut (
    .clk(clk), .reset(reset),
    .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
    .r_data(r_data), .r_dvalid(r_dvalid),
    .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port synchronous RAM, read data one cycle after the access
  bit [15:0] mem [bit [15:0]];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 16'h0;
    end
  end

  typedef struct {
    int          due;
    int          port;
    logic [15:0] data;
  } ret_t;

  int          ptr;
  logic        req_v [6];
  logic [15:0] req_a [6];
  logic [15:0] req_d [6];
  int          wait_cnt [6];
  bit   [15:0] shadow [bit [15:0]];
  ret_t        rq [$];
  logic [15:0] exp_rd [3];
  int          cyc;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] d);
    req_v[idx]    = 1'b1;
    req_a[idx]    = a;
    req_d[idx]    = d;
    wait_cnt[idx] = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      r_avalid[k]          = req_v[2*k];
      r_addr[k*NA +: NA]   = req_a[2*k];
      w_valid[k]           = req_v[2*k+1];
      w_addr[k*NA +: NA]   = req_a[2*k+1];
      w_data[k*ND +: ND]   = req_d[2*k+1];
    end
  endtask

  // One clock: drive, check outputs mid-cycle, then advance the model
  task automatic step();
    int          g;
    int          idx;
    logic [5:0]  ready6;
    logic [2:0]  dv;
    logic [15:0] a;
    drive();
    @(negedge clk);
    g = -1;
    if (!reset) begin
      for (int k = 0; k < 6; k++) begin
        idx = (ptr + k) % 6;
        if (g < 0 && req_v[idx]) g = idx;
      end
    end
    ready6 = {w_ready[2], r_aready[2], w_ready[1], r_aready[1], w_ready[0], r_aready[0]};
    check("ready", 64'(ready6), (g >= 0) ? (64'd1 << g) : 64'd0);
    check("ram_en", 64'(ram_en), 64'(g >= 0));
    check("ram_we", 64'(ram_we), 64'(g >= 0 && (g % 2) == 1));
    check("ram_addr", 64'(ram_addr), (g >= 0) ? 64'(req_a[g]) : 64'd0);
    if (g < 0 || (g % 2) == 1)
      check("ram_wdata", 64'(ram_wdata), (g >= 0) ? 64'(req_d[g]) : 64'd0);
    dv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      dv[rq[0].port]     = 1'b1;
      exp_rd[rq[0].port] = rq[0].data;
      void'(rq.pop_front());
    end
    check("r_dvalid", 64'(r_dvalid), 64'(dv));
    check("r_data", 64'(r_data), 64'({exp_rd[2], exp_rd[1], exp_rd[0]}));
    if (g >= 0) check("starve", 64'(wait_cnt[g] < 6), 64'd1);
    @(posedge clk);
    if (reset) begin
      ptr = 0;
      rq.delete();
      for (int k = 0; k < 3; k++) exp_rd[k] = 16'h0;
      for (int k = 0; k < 6; k++) wait_cnt[k] = 0;
    end else begin
      for (int k = 0; k < 6; k++)
        if (req_v[k] && k != g) wait_cnt[k]++;
      if (g >= 0) begin
        ptr = (g + 1) % 6;
        a   = req_a[g];
        if ((g % 2) == 0)
          rq.push_back('{cyc + 2, g / 2, shadow.exists(a) ? shadow[a] : 16'h0});
        else
          shadow[a] = req_d[g];
        req_v[g]    = 1'b0;
        wait_cnt[g] = 0;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    ptr    = 0;
    reset  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_v[k] = 1'b0; req_a[k] = 16'h0; req_d[k] = 16'h0; wait_cnt[k] = 0;
    end
    for (int k = 0; k < 3; k++) exp_rd[k] = 16'h0;
    drive();
    @(posedge clk);
    #1;
    cyc++;
    repeat (2) step();
    reset = 1'b0;

    // Single read of a location preloaded through w0
    set_req(1, 16'h0010, 16'hBEEF);
    step();
    set_req(0, 16'h0010, 16'h0);
    repeat (3) step();
    check("single_read_data", 64'(r_data[15:0]), 64'hBEEF);

    // Write then read of the same address: r1 granted right after w0
    set_req(1, 16'h0020, 16'h1234);
    set_req(2, 16'h0020, 16'h0);
    repeat (5) step();
    check("raw_data", 64'(r_data[31:16]), 64'h1234);

    // All six requesting continuously from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (24) begin
      for (int k = 0; k < 6; k++)
        if (!req_v[k]) set_req(k, 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom));
      step();
    end
    repeat (6) step();

    // Idle bank
    repeat (10) step();

    // Pointer resume after a w1 grant
    set_req(3, 16'h0103, 16'hA5A5);
    step();
    set_req(0, 16'h0103, 16'h0);
    set_req(4, 16'h0020, 16'h0);
    repeat (5) step();

    // Reset right after an r2 grant
    set_req(4, 16'h0010, 16'h0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 16'h0020, 16'h0);
    set_req(4, 16'h0010, 16'h0);
    repeat (5) step();

    // Randomized traffic with occasional resets
    repeat (400) begin
      reset = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 6; k++)
        if (!req_v[k] && $urandom_range(0, 2) != 0)
          set_req(k, 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom));
      step();
    end
    reset = 1'b0;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiram_bank_arbiter.md
Name: multiram_bank_arbiter

Overview:
- Shares one single-port synchronous RAM bank between three read requesters (r0..r2) and three write requesters (w0..w2).
- Each requester uses a valid/ready address handshake; read data returns on a fixed-latency, port-tagged return path.
- Sits between the multibank memory front-end ports and each physical RAM bank; one instance per bank.
- Fair round-robin arbitration over all six requesters, one RAM access per cycle.

Parameters:
- na, 16, address bus width.
- nd, 16, data bus width (read and write data).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- r_addr  in  3*na  read addresses; slice i = [i*na +: na] belongs to ri.
- r_avalid  in  3  1 = read request from ri.
- r_aready  out  3  1 = read address of ri accepted this cycle.
- r_data  out  3*nd  read data; slice i belongs to ri.
- r_dvalid  out  3  1 = r_data slice i valid, one-cycle pulse.
- w_addr  in  3*na  write addresses, sliced as r_addr.
- w_data  in  3*nd  write data, sliced per port.
- w_valid  in  3  1 = write request from wi.
- w_ready  out  3  1 = write of wi accepted this cycle.
- ram_en  out  1  1 = RAM access this cycle.
- ram_we  out  1  1 = write, 0 = read (meaningful only when ram_en = 1).
- ram_addr  out  na  RAM address.
- ram_wdata  out  nd  RAM write data.
- ram_rdata  in  nd  RAM read data, valid the cycle after a read access.

Behaviour:
- Requester index order: 0 = r0, 1 = w0, 2 = r1, 3 = w1, 4 = r2, 5 = w2.
- Round-robin pointer ptr (0..5), reset value 0.
- Each cycle, the first active request found searching from ptr upward (mod 6) is granted.
- Grant is combinational in the same cycle: the matching r_aready or w_ready bit = 1; all other ready bits = 0.
- On a grant to index g, ptr <= (g+1) mod 6. With no request, ptr holds.
- Handshake:
  - A requester holds valid, addr and data stable until ready = 1.
  - The transfer completes on the cycle where valid and ready are both 1.
  - Dropping valid before ready is a protocol error; no checking is required.
- RAM drive, combinational from the grant:
  - ram_en = 1 and ram_addr = granted address.
  - ram_we = 1 for a write index, with ram_wdata = that port's w_data.
  - With no grant: ram_en = 0, ram_we = 0, ram_addr and ram_wdata = 0.
- Read return pipeline:
  - Stage 1 registers the read valid flag and the port tag (0..2) at grant cycle T.
  - At T+1 ram_rdata is captured into the r_data slice of the tagged port.
  - At T+2 r_dvalid[tag] = 1 for one cycle.
  - Read latency from accepted handshake to dvalid is exactly 2 cycles.
  - r_data slices hold their last value between returns.
- Reads and writes to the same address in consecutive cycles follow RAM order.
  - A read granted one cycle after a write to the same address returns the new data.
- Throughput:
  - One access per cycle; back-to-back reads from different ports overlap in the pipeline.
  - A single port may be granted at most once per round when others are waiting.
- Starvation bound: any continuously asserted request is granted within 6 cycles.
- Reset values:
  - r_aready, w_ready, r_dvalid = 0.
  - r_data = 0.
  - ram_en, ram_we = 0; ram_addr, ram_wdata = 0.
  - Pipeline valid flags = 0; ptr = 0.
- Reset mid-operation:
  - In-flight reads are discarded; no r_dvalid pulse is issued for them after reset.
  - Grants are suppressed while reset = 1.

Test Plan:
- Single read: r_avalid = 3'b001, r_addr[0] = 16'h0010, RAM holds 16'hBEEF -> r_aready[0] = 1 at T; r_dvalid[0] = 1 at T+2 with r_data[0] = 16'hBEEF.
- Write then read: w0 writes 16'h1234 to 16'h0020 at T; r1 reads 16'h0020 with request asserted from T -> r1 granted at T+1, r_dvalid[1] at T+3 with data 16'h1234.
- All six requesting continuously from reset:
  - Grants occur in order r0, w0, r1, w1, r2, w2, r0, ...
  - Each port gets exactly one grant per 6 cycles.
  - ram_en stays 1 throughout.
- Idle bank: no requests for 10 cycles -> ram_en = 0, all ready and dvalid bits = 0, ptr unchanged.
- Pointer resume: last grant = w1 (ptr = 4); requests then arrive from r0 and r2 together -> r2 granted first, r0 next cycle.
- Reset mid-read: r2 granted at T, reset = 1 at T+1 -> no r_dvalid at T+2; all outputs 0; first grant after reset starts from r0.
